// File: rtl/obi_sram_responder.sv
// obi_sram_responder
// OBI device-side memory model. It serves the host from an internal array of
// 64-bit words. Grants can be held off with stall_i, and the number of
// accepted-but-unanswered transactions is capped. Responses come back in order
// through a fixed-length pipeline, and out-of-range accesses return an error.
module obi_sram_responder #(
    parameter logic [63:0] BASE_ADDR       = 64'h0,
    parameter int          DEPTH_WORDS     = 1024,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [7:0]  be_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    input  logic        stall_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [63:0] rdata_o,
    output logic        err_o
);

    localparam int               IDX_W      = $clog2(DEPTH_WORDS);
    localparam int               CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [63:0]      SPAN_BYTES = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [63:0]      mem [DEPTH_WORDS];
    logic [CNT_W-1:0] outstanding;

    logic             pipe_valid [LATENCY];
    logic             pipe_err   [LATENCY];
    logic [63:0]      pipe_data  [LATENCY];

    logic [63:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic             accept;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap to a huge
    // offset. The single compare against the array span therefore rejects
    // addresses both below and above the window.
    assign offset   = addr_i - BASE_ADDR;
    assign in_range = (offset < SPAN_BYTES);
    assign word_idx = offset[3 +: IDX_W];

    // The grant depends only on reset, stall and the registered count, never
    // on the request itself.
    assign gnt_o  = !rst_i && !stall_i && (outstanding < CNT_MAX);
    assign accept = req_i && gnt_o;

    // Byte-masked write at the accept edge. There is no reset, so the contents
    // survive rst_i. The grant is low during reset, so no write can land then.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response shift register. Stage 0 captures the read word at the accept
    // edge. A write issued one cycle later cannot disturb it, and a read issued
    // one cycle after a write sees the new data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_err[i]   <= 1'b0;
                pipe_data[i]  <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && !in_range;
            pipe_data[0]  <= (accept && !we_i && in_range) ? mem[word_idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    // Count of accepted but unanswered transactions. A slot frees at the end of
    // the cycle whose response is being presented.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else if (accept && !rvalid_o) begin
            outstanding <= outstanding + CNT_ONE;
        end else if (!accept && rvalid_o) begin
            outstanding <= outstanding - CNT_ONE;
        end
    end

    assign rvalid_o = pipe_valid[LATENCY-1];
    assign err_o    = pipe_err[LATENCY-1];
    assign rdata_o  = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_obi_sram_responder.sv
// Bench for obi_sram_responder. Three instances with different parameter sets
// share one clock. A queue-based reference model predicts the grant and
// response of every cycle.
module tb_obi_sram_responder;

    localparam int NDUT = 3;
    localparam logic [63:0] P_BASE  [NDUT] = '{64'h0, 64'h1000, 64'h0};
    localparam int          P_DEPTH [NDUT] = '{1024, 1024, 16};
    localparam int          P_LAT   [NDUT] = '{1, 3, 4};
    localparam int          P_MAX   [NDUT] = '{2, 3, 5};

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        req;
        logic        we;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
    } stim_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic        err;
        logic [63:0] rdata;
    } obs_t;

    typedef struct packed {
        logic [31:0] due;
        logic        err;
        logic [63:0] data;
    } resp_t;

    localparam stim_t IDLE = '0;

    logic        clk_i;
    logic        rst    [NDUT];
    logic        req    [NDUT];
    logic        we     [NDUT];
    logic [7:0]  be     [NDUT];
    logic [63:0] addr   [NDUT];
    logic [63:0] wdata  [NDUT];
    logic        stall  [NDUT];
    logic        gnt    [NDUT];
    logic        rvalid [NDUT];
    logic [63:0] rdata  [NDUT];
    logic        err    [NDUT];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: the expected responses in acceptance order, each tagged
    // with the cycle in which it must appear, plus a shadow of each array.
    resp_t       exp_q[$];
    logic [63:0] mdl_mem [NDUT][1024];

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        obi_sram_responder #(
            .BASE_ADDR      (P_BASE[k]),
            .DEPTH_WORDS    (P_DEPTH[k]),
            .LATENCY        (P_LAT[k]),
            .MAX_OUTSTANDING(P_MAX[k])
        ) u_dut (
            .clk_i   (clk_i),
            .rst_i   (rst[k]),
            .req_i   (req[k]),
            .we_i    (we[k]),
            .be_i    (be[k]),
            .addr_i  (addr[k]),
            .wdata_i (wdata[k]),
            .stall_i (stall[k]),
            .gnt_o   (gnt[k]),
            .rvalid_o(rvalid[k]),
            .rdata_o (rdata[k]),
            .err_o   (err[k])
        );
    end

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic stim_t wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] b);
        stim_t s;
        s = '0;
        s.req = 1'b1; s.we = 1'b1; s.be = b; s.addr = a; s.wdata = d;
        return s;
    endfunction

    function automatic stim_t rd(input logic [63:0] a);
        stim_t s;
        s = '0;
        s.req = 1'b1; s.be = 8'hFF; s.addr = a;
        return s;
    endfunction

    // Drives one cycle, samples the DUT mid-cycle and advances the model.
    task automatic run_cycle(input int d, input stim_t s, output obs_t o, output obs_t e);
        logic [63:0] off;
        logic        inr;
        int          idx;
        resp_t       r;
        @(negedge clk_i);
        rst[d] = s.rst; stall[d] = s.stall; req[d] = s.req; we[d] = s.we;
        be[d] = s.be; addr[d] = s.addr; wdata[d] = s.wdata;
        #1;
        o.gnt = gnt[d]; o.rvalid = rvalid[d]; o.err = err[d]; o.rdata = rdata[d];
        e = '0;
        e.gnt = !s.rst && !s.stall && (exp_q.size() < P_MAX[d]);
        if (exp_q.size() > 0 && int'(exp_q[0].due) == cyc) begin
            r = exp_q.pop_front();
            e.rvalid = 1'b1; e.err = r.err; e.rdata = r.data;
        end
        if (s.rst) begin
            exp_q.delete();
        end else if (s.req && e.gnt) begin
            off = s.addr - P_BASE[d];
            inr = off < 64'(P_DEPTH[d]) * 64'd8;
            idx = inr ? int'(off >> 3) : 0;
            r.due  = 32'(cyc + P_LAT[d]);
            r.err  = !inr;
            r.data = (inr && !s.we) ? mdl_mem[d][idx] : 64'h0;
            if (inr && s.we) begin
                for (int b = 0; b < 8; b++) begin
                    if (s.be[b]) mdl_mem[d][idx][8*b +: 8] = s.wdata[8*b +: 8];
                end
            end
            exp_q.push_back(r);
        end
    endtask

    task automatic write_word(input int d, input logic [63:0] a, input logic [63:0] v);
        obs_t o, e;
        bit   done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            run_cycle(d, wr(a, v, 8'hFF), o, e);
            done = o.gnt;
        end
        n_assert++;
        if (!done) begin
            n_fail++;
            $display("FAIL write_word dut%0d addr %h: gnt never seen, required within 20 cycles", d, a);
        end
    endtask

    task automatic drain(input int d);
        obs_t o, e;
        for (int i = 0; i < P_LAT[d] + 2; i++) run_cycle(d, IDLE, o, e);
    endtask

    task automatic test_reset();
        obs_t  o, e, want;
        stim_t s;
        for (int d = 0; d < NDUT; d++) begin
            s = IDLE;
            s.rst = 1'b1;
            run_cycle(d, s, o, e);
            run_cycle(d, s, o, e);
            n_assert++;
            if (o !== '0) begin
                n_fail++;
                $display("FAIL reset_hold dut%0d: got %h required %h", d, o, obs_t'('0));
            end
            run_cycle(d, IDLE, o, e);
            want = '0;
            want.gnt = 1'b1;
            n_assert++;
            if (o !== want) begin
                n_fail++;
                $display("FAIL reset_release dut%0d: got %h required %h", d, o, want);
            end
        end
    endtask

    task automatic test_write_read();
        obs_t  o, e;
        stim_t seq[$];
        logic  exp_rv;
        logic [63:0] exp_rd;
        seq = '{wr(64'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF), rd(64'h40), IDLE, IDLE, IDLE};
        for (int c = 0; c < seq.size(); c++) begin
            run_cycle(0, seq[c], o, e);
            n_assert++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL write_read model c%0d: got %h required %h", c, o, e);
            end
            exp_rv = (c == 1 || c == 2);
            exp_rd = (c == 2) ? 64'hDEADBEEF_CAFEF00D : 64'h0;
            n_assert++;
            if (o.rvalid !== exp_rv || o.rdata !== exp_rd || o.err !== 1'b0) begin
                n_fail++;
                $display("FAIL write_read c%0d: got rvalid=%b rdata=%h err=%b required rvalid=%b rdata=%h err=0",
                         c, o.rvalid, o.rdata, o.err, exp_rv, exp_rd);
            end
        end
    endtask

    task automatic test_byte_enables();
        obs_t        o, e;
        stim_t       seq[$];
        logic [63:0] resp[$];
        seq = '{wr(64'h08, 64'h0, 8'hFF), wr(64'h08, 64'h11223344_55667788, 8'h0F), rd(64'h08),
                wr(64'h08, 64'hFFFFFFFF_FFFFFFFF, 8'h00), rd(64'h08), IDLE, IDLE};
        for (int c = 0; c < seq.size(); c++) begin
            run_cycle(0, seq[c], o, e);
            if (o.rvalid) resp.push_back(o.rdata);
            n_assert++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL byte_enables model c%0d: got %h required %h", c, o, e);
            end
        end
        n_assert++;
        if (resp.size() != 5) begin
            n_fail++;
            $display("FAIL byte_enables count: got %0d responses required 5", resp.size());
        end else begin
            n_assert++;
            if (resp[2] !== 64'h00000000_55667788 || resp[4] !== 64'h00000000_55667788) begin
                n_fail++;
                $display("FAIL byte_enables data: got %h / %h required 0000000055667788", resp[2], resp[4]);
            end
        end
    endtask

    task automatic test_errors();
        obs_t        o, e;
        stim_t       seq[$];
        logic [64:0] resp[$];
        logic [64:0] want[$];
        for (int d = 0; d < 2; d++) begin
            resp.delete();
            if (d == 0) begin
                seq  = '{wr(64'h0, 64'hA5A5A5A5_A5A5A5A5, 8'hFF), rd(64'h2000),
                         wr(64'h2000, 64'hFFFFFFFF_FFFFFFFF, 8'hFF), rd(64'h0), IDLE, IDLE};
                want = '{{1'b0, 64'h0}, {1'b1, 64'h0}, {1'b1, 64'h0}, {1'b0, 64'hA5A5A5A5_A5A5A5A5}};
            end else begin
                seq  = '{wr(64'h2FF8, 64'h0123_4567_89AB_CDEF, 8'hFF), IDLE, rd(64'h0FF8), IDLE,
                         wr(64'h0FF8, 64'hFFFFFFFF_FFFFFFFF, 8'hFF), IDLE, rd(64'h3000), IDLE,
                         rd(64'h2FF8), IDLE, IDLE, IDLE, IDLE};
                want = '{{1'b0, 64'h0}, {1'b1, 64'h0}, {1'b1, 64'h0}, {1'b1, 64'h0},
                         {1'b0, 64'h0123_4567_89AB_CDEF}};
            end
            for (int c = 0; c < seq.size(); c++) begin
                run_cycle(d, seq[c], o, e);
                if (o.rvalid) resp.push_back({o.err, o.rdata});
                n_assert++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL errors model dut%0d c%0d: got %h required %h", d, c, o, e);
                end
            end
            n_assert++;
            if (resp.size() != want.size()) begin
                n_fail++;
                $display("FAIL errors count dut%0d: got %0d responses required %0d", d, resp.size(), want.size());
            end else begin
                for (int i = 0; i < want.size(); i++) begin
                    n_assert++;
                    if (resp[i] !== want[i]) begin
                        n_fail++;
                        $display("FAIL errors resp dut%0d #%0d: got err/data %h required %h", d, i, resp[i], want[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        obs_t  o, e;
        stim_t s;
        int    n_acc, acc_c, n_rv, rv_c;
        logic [63:0] rv_data;
        write_word(0, 64'h10, 64'hC0FFEE00_12345678);
        drain(0);
        n_acc = 0; acc_c = -1; n_rv = 0; rv_c = -1; rv_data = '0;
        for (int c = 0; c <= 10; c++) begin
            s = (c >= 3 && c <= 7) ? rd(64'h10) : IDLE;
            s.stall = (c >= 3 && c <= 6);
            run_cycle(0, s, o, e);
            if (s.req && o.gnt) begin n_acc++; acc_c = c; end
            if (o.rvalid) begin n_rv++; rv_c = c; rv_data = o.rdata; end
            n_assert++;
            if (o.gnt !== !(c >= 3 && c <= 6)) begin
                n_fail++;
                $display("FAIL backpressure gnt c%0d: got %b required %b", c, o.gnt, !(c >= 3 && c <= 6));
            end
            n_assert++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL backpressure model c%0d: got %h required %h", c, o, e);
            end
        end
        n_assert++;
        if (n_acc != 1 || acc_c != 7 || n_rv != 1 || rv_c != 8 || rv_data !== 64'hC0FFEE00_12345678) begin
            n_fail++;
            $display("FAIL backpressure summary: got accepts=%0d@%0d rvalids=%0d@%0d data=%h required 1@7 1@8 c0ffee0012345678",
                     n_acc, acc_c, n_rv, rv_c, rv_data);
        end
    endtask

    task automatic test_outstanding();
        obs_t  o, e;
        stim_t s;
        logic  exp_g, exp_rv;
        for (int i = 0; i < 8; i++) write_word(1, 64'h1000 + 64'(8 * i), {$urandom, $urandom});
        drain(1);
        for (int c = 0; c < 14; c++) begin
            s = (c < 12) ? rd(64'h1000 + 64'(8 * (c % 8))) : IDLE;
            run_cycle(1, s, o, e);
            exp_g  = (c % 4 != 3);
            exp_rv = (c >= 3) && ((c - 3) % 4 != 3);
            n_assert++;
            if ((c < 12 && o.gnt !== exp_g) || o.rvalid !== exp_rv) begin
                n_fail++;
                $display("FAIL outstanding c%0d: got gnt=%b rvalid=%b required gnt=%b rvalid=%b",
                         c, o.gnt, o.rvalid, exp_g, exp_rv);
            end
            n_assert++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL outstanding model c%0d: got %h required %h", c, o, e);
            end
        end
        drain(1);
    endtask

    task automatic test_reset_midflight();
        obs_t  o, e;
        stim_t s;
        int    n_rv;
        logic [63:0] rv_data;
        write_word(2, 64'h20, 64'h5A5A0000_FFFF1234);
        drain(2);
        for (int c = 0; c <= 10; c++) begin
            s = (c < 2) ? rd(64'h20) : IDLE;
            s.rst = (c == 3);
            run_cycle(2, s, o, e);
            n_assert++;
            if (o.rvalid !== 1'b0 || (c == 3 && o.gnt !== 1'b0) || (c == 4 && o.gnt !== 1'b1)) begin
                n_fail++;
                $display("FAIL reset_midflight c%0d: got rvalid=%b gnt=%b required rvalid=0 gnt=%b",
                         c, o.rvalid, o.gnt, (c != 3));
            end
            n_assert++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_midflight model c%0d: got %h required %h", c, o, e);
            end
        end
        n_rv = 0; rv_data = '0;
        for (int c = 0; c < 7; c++) begin
            run_cycle(2, (c == 0) ? rd(64'h20) : IDLE, o, e);
            if (o.rvalid) begin
                n_rv++;
                rv_data = o.rdata;
                n_assert++;
                if (c != 4) begin
                    n_fail++;
                    $display("FAIL reset_readback timing: got rvalid at c%0d required c4", c);
                end
            end
        end
        n_assert++;
        if (n_rv != 1 || rv_data !== 64'h5A5A0000_FFFF1234) begin
            n_fail++;
            $display("FAIL reset_readback: got %0d responses data=%h required 1 data=5a5a0000ffff1234", n_rv, rv_data);
        end
    endtask

    task automatic test_random();
        obs_t  o, e;
        stim_t s;
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 8; i++) write_word(d, P_BASE[d] + 64'(8 * i), {$urandom, $urandom});
            drain(d);
            for (int c = 0; c < 300 + P_LAT[d] + 2; c++) begin
                s = IDLE;
                if (c < 300) begin
                    s.req   = ($urandom_range(0, 9) < 7);
                    s.we    = 1'($urandom_range(0, 1));
                    s.be    = 8'($urandom);
                    s.stall = ($urandom_range(0, 9) < 2);
                    s.wdata = {$urandom, $urandom};
                    case ($urandom_range(0, 9))
                        0:       s.addr = {$urandom, $urandom};
                        1:       s.addr = P_BASE[d] + 64'(P_DEPTH[d]) * 64'd8 + 64'($urandom_range(0, 4095));
                        2:       s.addr = P_BASE[d] - 64'($urandom_range(1, 4096));
                        default: s.addr = P_BASE[d] + 64'($urandom_range(0, 63));
                    endcase
                end
                run_cycle(d, s, o, e);
                n_assert++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL random dut%0d c%0d: got %h required %h", d, c, o, e);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; stall[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
            be[d] = '0; addr[d] = '0; wdata[d] = '0;
        end
        test_reset();
        test_write_read();
        test_byte_enables();
        test_errors();
        test_backpressure();
        test_outstanding();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
